video_cursor_overlay: RTL

VIDEO_CURSOR_OVERLAY -- requirements
Module: video_cursor_overlay

---
 rtl/video_cursor_overlay.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/video_cursor_overlay.sv
// Character-cell cursor overlay on a pixel stream: inverts colour under the cursor cell
// (block or underline, optional blink) and muxes the registered pixel onto a 12-bit DVI bus.
module video_cursor_overlay #(
  parameter int unsigned X0           = 415,
  parameter int unsigned Y0           = 50,
  parameter int unsigned CELL_W       = 24,
  parameter int unsigned CELL_H       = 24,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned UL_LINES     = 3
) (
  input  logic        pixel2_clk,
  input  logic        irst,
  input  logic [7:0]  red_in,
  input  logic [7:0]  green_in,
  input  logic [7:0]  blue_in,
  input  logic        hsyn_in,
  input  logic        vsyn_in,
  input  logic        blank_in,
  input  logic [6:0]  cursor_x,
  input  logic [5:0]  cursor_y,
  input  logic        cursor_en,
  input  logic        cursor_ul,
  input  logic        blink_en,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsyn,
  output logic        vsyn,
  output logic        blank,
  output logic [11:0] DVI_D,
  output logic        DVI_DE,
  output logic        DVI_H,
  output logic        DVI_V,
  output logic        DVI_XCLK_P,
  output logic        DVI_XCLK_N
);

  localparam int unsigned FcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [7:0]     red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic           hsyn_q, vsyn_q, blank_q;
  logic [11:0]    hcnt_q, hcnt_d;
  logic [10:0]    lcnt_q, lcnt_d;
  logic [6:0]     cx_q, cx_d;
  logic [5:0]     cy_q, cy_d;
  logic           en_q, en_d, ul_q, ul_d;
  logic [FcW-1:0] frame_q, frame_d;
  logic           blink_phase_q, blink_phase_d;
  logic           dvi_phase_q, dvi_phase_d;

  logic        hsyn_rise, hsyn_fall, vsyn_rise, vsyn_fall;
  logic [15:0] hx, ly, col_lo, col_hi, row_lo, row_hi, ul_lo;
  logic        in_x, in_y, in_ul, range_ok, invert;

  // The registered sync outputs double as the edge-detector history.
  assign hsyn_rise = hsyn_in & ~hsyn_q;
  assign hsyn_fall = ~hsyn_in & hsyn_q;
  assign vsyn_rise = vsyn_in & ~vsyn_q;
  assign vsyn_fall = ~vsyn_in & vsyn_q;

  // Cell bounds at 16 bits so X0 + cx * CELL_W never wraps.
  always_comb begin
    hx       = {4'b0, hcnt_q};
    ly       = {5'b0, lcnt_q};
    col_lo   = 16'(X0) + 16'(cx_q) * 16'(CELL_W);
    col_hi   = col_lo + 16'(CELL_W);
    row_lo   = 16'(Y0) + 16'(cy_q) * 16'(CELL_H);
    row_hi   = row_lo + 16'(CELL_H);
    ul_lo    = row_hi - 16'(UL_LINES);
    in_x     = (hx >= col_lo) && (hx < col_hi);
    in_y     = (ly >= row_lo) && (ly < row_hi);
    in_ul    = (ly >= ul_lo);
    range_ok = (cx_q < 7'd64) && (cy_q < 6'd32);
    invert   = en_q & ~blink_phase_q & in_x & in_y & (~ul_q | in_ul) & range_ok;
  end

  always_comb begin
    red_d   = 8'h00;
    green_d = 8'h00;
    blue_d  = 8'h00;
    if (!blank_in) begin
      red_d   = invert ? ~red_in   : red_in;
      green_d = invert ? ~green_in : green_in;
      blue_d  = invert ? ~blue_in  : blue_in;
    end

    hcnt_d = hcnt_q;
    if (hsyn_fall)           hcnt_d = 12'd0;
    else if (hcnt_q != '1)   hcnt_d = hcnt_q + 12'd1;

    lcnt_d = lcnt_q;
    if (vsyn_fall)                      lcnt_d = 11'd0;
    else if (hsyn_fall && lcnt_q != '1) lcnt_d = lcnt_q + 11'd1;

    cx_d = cx_q;
    cy_d = cy_q;
    en_d = en_q;
    ul_d = ul_q;
    if (vsyn_rise) begin
      cx_d = cursor_x;
      cy_d = cursor_y;
      en_d = cursor_en;
      ul_d = cursor_ul;
    end

    frame_d       = frame_q;
    blink_phase_d = blink_phase_q;
    if (!blink_en) begin
      frame_d       = '0;
      blink_phase_d = 1'b0;
    end else if (vsyn_rise) begin
      if (frame_q == FcW'(BLINK_FRAMES - 1)) begin
        frame_d       = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_d = frame_q + FcW'(1);
      end
    end

    dvi_phase_d = hsyn_rise ? 1'b0 : ~dvi_phase_q;
  end

  always_ff @(posedge pixel2_clk) begin
    if (irst) begin
      red_q         <= 8'h00;
      green_q       <= 8'h00;
      blue_q        <= 8'h00;
      hsyn_q        <= 1'b0;
      vsyn_q        <= 1'b0;
      blank_q       <= 1'b0;
      hcnt_q        <= 12'd0;
      lcnt_q        <= 11'd0;
      cx_q          <= 7'd0;
      cy_q          <= 6'd0;
      en_q          <= 1'b0;
      ul_q          <= 1'b0;
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
      dvi_phase_q   <= 1'b0;
    end else begin
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      hsyn_q        <= hsyn_in;
      vsyn_q        <= vsyn_in;
      blank_q       <= blank_in;
      hcnt_q        <= hcnt_d;
      lcnt_q        <= lcnt_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      en_q          <= en_d;
      ul_q          <= ul_d;
      frame_q       <= frame_d;
      blink_phase_q <= blink_phase_d;
      dvi_phase_q   <= dvi_phase_d;
    end
  end

  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign hsyn       = hsyn_q;
  assign vsyn       = vsyn_q;
  assign blank      = blank_q;
  assign DVI_D      = blank_q     ? 12'h000 :
                      dvi_phase_q ? {red_q, green_q[7:4]} : {green_q[3:0], blue_q};
  // Held low while in reset so the link shows no active video.
  assign DVI_DE     = ~blank_q & ~irst;
  assign DVI_H      = hsyn_q;
  assign DVI_V      = vsyn_q;
  assign DVI_XCLK_P = ~dvi_phase_q;
  assign DVI_XCLK_N = dvi_phase_q;

endmodule
